mem_access_arbiter: RTL

Multi-cycle arbiter and sequencer for the single-ported data memory behind the MEM pipeline stage. It shares the memory between the pipeline's load/store path and a DMA/debug requester. It drives memory enables, address and write data from registered copies for a fixed number of wait states. It freezes the pipeline via `pipe_stall` until the pipeline's own access completes.

---
 rtl/mem_access_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one single-ported data memory between the
// pipeline load/store path and a DMA/debug requester. Each access is held
// on registered memory controls for WAIT_STATES+1 cycles. The pipeline is
// stalled until its own access reaches the DONE cycle.
module mem_access_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2   // legal range 0..15
) (
  input  logic                  clk,
  input  logic                  reset,          // async, active-low
  // pipeline MEM stage
  input  logic                  pipe_read_en,
  input  logic                  pipe_write_en,
  input  logic [DATA_WIDTH-1:0] pipe_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic [DATA_WIDTH-1:0] pipe_rdata,
  output logic                  pipe_stall,
  // DMA / debug requester
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [DATA_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  // memory port
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
  typedef enum logic       {GR_PIPE, GR_DMA}             grant_e;

  state_e                state_q, state_d;
  grant_e                grant_q, grant_d;
  grant_e                last_grant_q, last_grant_d;
  grant_e                winner;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  req_we_q, req_we_d;
  logic                  mem_read_en_q, mem_read_en_d;
  logic                  mem_write_en_q, mem_write_en_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] pipe_rdata_q, pipe_rdata_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic                  dma_ack_q, dma_ack_d;
  logic                  pipe_req;

  // Both enables high counts as a single store request.
  assign pipe_req = pipe_read_en | pipe_write_en;

  // Round-robin choice: on a tie the requester not served last time wins.
  always_comb begin
    if (pipe_req && dma_req) begin
      winner = (last_grant_q == GR_DMA) ? GR_PIPE : GR_DMA;
    end else if (pipe_req) begin
      winner = GR_PIPE;
    end else begin
      winner = GR_DMA;
    end
  end

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    wait_cnt_d     = wait_cnt_q;
    req_we_d       = req_we_q;
    mem_read_en_d  = mem_read_en_q;
    mem_write_en_d = mem_write_en_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    pipe_rdata_d   = pipe_rdata_q;
    dma_rdata_d    = dma_rdata_q;
    dma_ack_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pipe_req || dma_req) begin
          grant_d    = winner;
          wait_cnt_d = '0;
          state_d    = ST_ACCESS;
          if (winner == GR_PIPE) begin
            req_we_d    = pipe_write_en;
            mem_addr_d  = pipe_addr;
            mem_wdata_d = pipe_wdata;
          end else begin
            req_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
          end
          mem_write_en_d = req_we_d;
          mem_read_en_d  = ~req_we_d;
        end
      end

      ST_ACCESS: begin
        if (wait_cnt_q == WAIT_LAST) begin
          // Memory data is valid in this final cycle; writes leave rdata alone.
          if (!req_we_q) begin
            if (grant_q == GR_PIPE) pipe_rdata_d = mem_rdata;
            else                    dma_rdata_d  = mem_rdata;
          end
          mem_read_en_d  = 1'b0;
          mem_write_en_d = 1'b0;
          dma_ack_d      = (grant_q == GR_DMA);
          state_d        = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        // Completion cycle: never launches, so the loser gets the next IDLE.
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= GR_PIPE;
      last_grant_q   <= GR_DMA;
      wait_cnt_q     <= '0;
      req_we_q       <= 1'b0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      pipe_rdata_q   <= '0;
      dma_rdata_q    <= '0;
      dma_ack_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      wait_cnt_q     <= wait_cnt_d;
      req_we_q       <= req_we_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      pipe_rdata_q   <= pipe_rdata_d;
      dma_rdata_q    <= dma_rdata_d;
      dma_ack_q      <= dma_ack_d;
    end
  end

  // Stall releases only in the pipeline's own DONE cycle, and never in reset.
  assign pipe_stall   = reset & pipe_req & ~((state_q == ST_DONE) & (grant_q == GR_PIPE));

  assign pipe_rdata   = pipe_rdata_q;
  assign dma_rdata    = dma_rdata_q;
  assign dma_ack      = dma_ack_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
